// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package down_timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot and auto-reload modes; pulses expired on reaching terminal.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             periodic_q, periodic_d;
    logic             expired_q, expired_d;
    logic             done_q, done_d;

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a load in any state overrides everything else.
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_value != ZERO) ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    if (enable && count_q <= ONE && !periodic_q) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Count/reload datapath: decrement is guarded, terminal either reloads or parks at zero.
    always_comb begin
        count_d    = count_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        expired_d  = 1'b0;
        done_d     = done_q;
        if (load) begin
            count_d    = load_value;
            reload_d   = load_value;
            periodic_d = periodic;
            done_d     = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (enable) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            expired_d = 1'b1;
                            if (periodic_q) begin
                                count_d = reload_q;
                            end else begin
                                count_d = ZERO;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                DONE:    count_d = ZERO;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            expired_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            expired_q  <= expired_d;
            done_q     <= done_d;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q == RUN);
    assign expired = expired_q;
    assign done    = done_q;

endmodule : down_timer
